// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner back end.
package keypad_pkg;

  localparam int unsigned KEY_W          = 4;
  localparam int unsigned DEF_DEB_CYCLES = 50000;
  localparam int unsigned DEF_REL_CYCLES = 50000;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_DEPTH      = 4;

  // Debounce FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } key_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);
  assign ovf_c   = push_i & full & ~do_pop;

  // Pointer advance
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are only observed through the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  assign head_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = empty;
  assign full_o  = full;

endmodule

// File: rtl/key_event_fifo.sv
// Debounces raw scanner output into one event per press and queues events.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned REL_CYCLES = DEF_REL_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             KeyRead,
  input  logic [KEY_W-1:0] BCDKey,
  input  logic             KEY_POP,
  input  logic             CLR_OVF,
  output logic [KEY_W-1:0] KEY_CODE,
  output logic             KEY_VALID,
  output logic             FULL,
  output logic             OVERFLOW
);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             ovf_q, ovf_d;
  logic             push_c;
  logic             fifo_empty, fifo_full, fifo_ovf_c;
  logic             press_bounce, press_done, rel_done;

  assign press_bounce = ~KeyRead | (BCDKey != code_q);
  assign press_done   = (cnt_q == CNT_W'(DEB_CYCLES - 1));
  assign rel_done     = (cnt_q == CNT_W'(REL_CYCLES - 1));

  // State, counter and latched-code registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (KeyRead) state_d = PRESS_DEB;
      end
      PRESS_DEB: begin
        if (press_bounce)    state_d = IDLE;
        else if (press_done) state_d = HELD;
      end
      HELD: begin
        if (!KeyRead) state_d = REL_DEB;
      end
      REL_DEB: begin
        if (KeyRead)       state_d = HELD;
        else if (rel_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter, code latch and push strobe per state
  always_comb begin
    cnt_d  = cnt_q;
    code_d = code_q;
    push_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (KeyRead) begin
          code_d = BCDKey;
          cnt_d  = CNT_W'(1);
        end
      end
      PRESS_DEB: begin
        if (press_bounce) begin
          cnt_d = '0;
        end else if (press_done) begin
          push_c = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!KeyRead) cnt_d = CNT_W'(1);
      end
      REL_DEB: begin
        if (KeyRead || rel_done) cnt_d = '0;
        else                     cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Sticky overflow; a new drop wins over a clear in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_ovf_c)   ovf_d = 1'b1;
    else if (CLR_OVF) ovf_d = 1'b0;
  end

  // Overflow register
  always_ff @(posedge CLK) begin
    if (!RESET) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (push_c),
    .data_i  (code_q),
    .pop_i   (KEY_POP),
    .head_o  (KEY_CODE),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .ovf_c   (fifo_ovf_c)
  );

  assign KEY_VALID = ~fifo_empty;
  assign FULL      = fifo_full;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo with short debounce windows.
module tb_key_event_fifo;

  logic       clk = 1'b0;
  logic       rst_n, kr, pop, clr;
  logic [3:0] code;
  logic [3:0] key_code;
  logic       key_valid, full, ovf;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  key_event_fifo #(
    .DEB_CYCLES (8),
    .REL_CYCLES (8),
    .CNT_W      (16),
    .DEPTH      (4)
  ) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .KeyRead   (kr),
    .BCDKey    (code),
    .KEY_POP   (pop),
    .CLR_OVF   (clr),
    .KEY_CODE  (key_code),
    .KEY_VALID (key_valid),
    .FULL      (full),
    .OVERFLOW  (ovf)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       kr;
    logic [3:0] code;
    logic       pop;
    logic       clr;
    int         cycles;
    logic       e_valid;
    logic [3:0] e_code;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic r, logic k, logic [3:0] c, logic p, logic cl,
                              int n, logic ev, logic [3:0] ec, logic ef, logic eo);
    vec_t v;
    v.name = nm; v.rst_n = r; v.kr = k; v.code = c; v.pop = p; v.clr = cl; v.cycles = n;
    v.e_valid = ev; v.e_code = ec; v.e_full = ef; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_all(string nm, logic ev, logic [3:0] ec, logic ef, logic eo);
    chk({nm, ".valid"}, {3'b0, key_valid}, {3'b0, ev});
    chk({nm, ".code"},  key_code, ec);
    chk({nm, ".full"},  {3'b0, full}, {3'b0, ef});
    chk({nm, ".ovf"},   {3'b0, ovf}, {3'b0, eo});
  endtask

  // Inputs change on the falling edge and are held for n rising edges.
  task automatic drive(logic r, logic k, logic [3:0] c, logic p, logic cl, int n);
    @(negedge clk);
    rst_n = r; kr = k; code = c; pop = p; clr = cl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; kr = 1'b0; code = 4'h0; pop = 1'b0; clr = 1'b0;

    // Reset, with other inputs active to show reset dominates
    drive(1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 2);
    chk_all("reset", 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2);
    chk_all("idle", 1'b0, 4'h0, 1'b0, 1'b0);

    // Clean press: push on the 8th edge with KeyRead high, visible in the 9th cycle
    @(negedge clk);
    kr = 1'b1; code = 4'h5;
    repeat (7) @(posedge clk);
    #1;
    chk("t1_lat_edge7.valid", {3'b0, key_valid}, 4'h0);
    @(posedge clk);
    #1;
    chk("t1_lat_edge8.valid", {3'b0, key_valid}, 4'h1);
    chk("t1_lat_edge8.code", key_code, 4'h5);
    drive(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 12);
    chk_all("t1_hold", 1'b1, 4'h5, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 20);
    chk_all("t1_release", 1'b1, 4'h5, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1);
    chk_all("t1_pop", 1'b0, 4'h0, 1'b0, 1'b0);

    // Bouncing KeyRead never reaches the press window
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 3);
      drive(1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 3);
    end
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 10);
    chk_all("t2_bounce", 1'b0, 4'h0, 1'b0, 1'b0);

    // Code change mid-debounce: 3 for 4 edges, then A restarts via IDLE (push at edge 13)
    vecs.push_back(mk("t3_code3",   1, 1, 4'h3, 0, 0, 4,  0, 4'h0, 0, 0));
    vecs.push_back(mk("t3_a_early", 1, 1, 4'hA, 0, 0, 7,  0, 4'h0, 0, 0));
    vecs.push_back(mk("t3_a_push",  1, 1, 4'hA, 0, 0, 2,  1, 4'hA, 0, 0));
    vecs.push_back(mk("t3_a_hold",  1, 1, 4'hA, 0, 0, 3,  1, 4'hA, 0, 0));
    vecs.push_back(mk("t3_release", 1, 0, 4'h0, 0, 0, 12, 1, 4'hA, 0, 0));
    vecs.push_back(mk("t3_pop",     1, 0, 4'h0, 1, 0, 1,  0, 4'h0, 0, 0));
    // Release bounce, re-touch with a different code gives no new event
    vecs.push_back(mk("t4_press",   1, 1, 4'h7, 0, 0, 12, 1, 4'h7, 0, 0));
    vecs.push_back(mk("t4_drop3",   1, 0, 4'h7, 0, 0, 3,  1, 4'h7, 0, 0));
    vecs.push_back(mk("t4_rise2",   1, 1, 4'h9, 0, 0, 2,  1, 4'h7, 0, 0));
    vecs.push_back(mk("t4_release", 1, 0, 4'h0, 0, 0, 12, 1, 4'h7, 0, 0));
    vecs.push_back(mk("t4_pop",     1, 0, 4'h0, 1, 0, 1,  0, 4'h0, 0, 0));
    // Pop on empty is ignored; push with pop on empty keeps the push
    vecs.push_back(mk("e_pop_empty",1, 0, 4'h0, 1, 0, 1,  0, 4'h0, 0, 0));
    vecs.push_back(mk("e_press",    1, 1, 4'hD, 0, 0, 7,  0, 4'h0, 0, 0));
    vecs.push_back(mk("e_push_pop", 1, 1, 4'hD, 1, 0, 1,  1, 4'hD, 0, 0));
    vecs.push_back(mk("e_hold",     1, 1, 4'hD, 0, 0, 2,  1, 4'hD, 0, 0));
    vecs.push_back(mk("e_release",  1, 0, 4'h0, 0, 0, 10, 1, 4'hD, 0, 0));
    vecs.push_back(mk("e_pop",      1, 0, 4'h0, 1, 0, 1,  0, 4'h0, 0, 0));
    // Overflow: five presses into a 4-deep FIFO
    for (int c = 1; c <= 5; c++) begin
      vecs.push_back(mk($sformatf("t5_press%0d", c), 1, 1, 4'(c), 0, 0, 10,
                        1, 4'h1, (c >= 4), (c == 5)));
      vecs.push_back(mk($sformatf("t5_rel%0d", c), 1, 0, 4'h0, 0, 0, 10,
                        1, 4'h1, (c >= 4), (c == 5)));
    end
    vecs.push_back(mk("t5_pop1",    1, 0, 4'h0, 1, 0, 1,  1, 4'h2, 0, 1));
    vecs.push_back(mk("t5_pop2",    1, 0, 4'h0, 1, 0, 1,  1, 4'h3, 0, 1));
    vecs.push_back(mk("t5_pop3",    1, 0, 4'h0, 1, 0, 1,  1, 4'h4, 0, 1));
    vecs.push_back(mk("t5_pop4",    1, 0, 4'h0, 1, 0, 1,  0, 4'h0, 0, 1));
    vecs.push_back(mk("t5_clr",     1, 0, 4'h0, 0, 1, 1,  0, 4'h0, 0, 0));
    // Refill with 6..9, then push+pop while full, then set-vs-clear priority
    for (int c = 6; c <= 9; c++) begin
      vecs.push_back(mk($sformatf("f_press%0d", c), 1, 1, 4'(c), 0, 0, 10,
                        1, 4'h6, (c == 9), 0));
      vecs.push_back(mk($sformatf("f_rel%0d", c), 1, 0, 4'h0, 0, 0, 10,
                        1, 4'h6, (c == 9), 0));
    end
    vecs.push_back(mk("f_b_deb",    1, 1, 4'hB, 0, 0, 7,  1, 4'h6, 1, 0));
    vecs.push_back(mk("f_b_pushpop",1, 1, 4'hB, 1, 0, 1,  1, 4'h7, 1, 0));
    vecs.push_back(mk("f_b_hold",   1, 1, 4'hB, 0, 0, 2,  1, 4'h7, 1, 0));
    vecs.push_back(mk("f_b_rel",    1, 0, 4'h0, 0, 0, 10, 1, 4'h7, 1, 0));
    vecs.push_back(mk("f_c_deb",    1, 1, 4'hC, 0, 0, 7,  1, 4'h7, 1, 0));
    vecs.push_back(mk("f_c_setclr", 1, 1, 4'hC, 0, 1, 1,  1, 4'h7, 1, 1));
    vecs.push_back(mk("f_c_hold",   1, 1, 4'hC, 0, 0, 2,  1, 4'h7, 1, 1));
    vecs.push_back(mk("f_c_rel",    1, 0, 4'h0, 0, 0, 10, 1, 4'h7, 1, 1));
    vecs.push_back(mk("f_clr",      1, 0, 4'h0, 0, 1, 1,  1, 4'h7, 1, 0));
    // Reset mid-press with two entries queued
    vecs.push_back(mk("t6_pop1",    1, 0, 4'h0, 1, 0, 1,  1, 4'h8, 0, 0));
    vecs.push_back(mk("t6_pop2",    1, 0, 4'h0, 1, 0, 1,  1, 4'h9, 0, 0));
    vecs.push_back(mk("t6_deb",     1, 1, 4'hD, 0, 0, 4,  1, 4'h9, 0, 0));
    vecs.push_back(mk("t6_reset",   0, 1, 4'hD, 0, 0, 1,  0, 4'h0, 0, 0));
    vecs.push_back(mk("t6_after",   1, 0, 4'h0, 0, 0, 12, 0, 4'h0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].kr, vecs[i].code, vecs[i].pop, vecs[i].clr, vecs[i].cycles);
      chk_all(vecs[i].name, vecs[i].e_valid, vecs[i].e_code, vecs[i].e_full, vecs[i].e_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
